// File: rtl/sigmoid_pwl_pkg.sv
// Shared constants and types for the piecewise-linear sigmoid block.
package sigmoid_pkg;

    localparam int SIG_BITS = 16;
    localparam int SIG_FRAC = 8;

    localparam logic [15:0] ONE_Q88 = 16'h0100;
    localparam logic [2:0]  SEG_MAX = 3'd5;

    typedef logic [2:0] seg_t;

    typedef struct packed {
        logic [15:0] g;
        logic [15:0] o;
    } seg_coef_t;

    // Gradient and offset per segment, index 0 first.
    localparam logic [0:5][15:0] GRAD_TBL = {
        16'h003B, 16'h0026, 16'h0012, 16'h0008, 16'h0003, 16'h0001
    };
    localparam logic [0:5][15:0] OFFS_TBL = {
        16'h0080, 16'h0090, 16'h00BD, 16'h00DD, 16'h00F0, 16'h00F9
    };

endpackage

// File: rtl/sigmoid_pwl_if.sv
// Operand/result bus of the sigmoid block.
interface sigmoid_pwl_if #(
    parameter int BITS = 16
);
    logic            in_valid;
    logic [BITS-1:0] x;
    logic            out_valid;
    logic [BITS-1:0] alfa;

    modport master (output in_valid, output x, input out_valid, input alfa);
    modport slave  (input in_valid, input x, output out_valid, output alfa);
endinterface

// File: rtl/sigmoid_pwl_seg_lut.sv
// Segment index to {gradient, offset} lookup; indices past the last
// segment fall back to the tail segment.
module sigmoid_seg_lut
    import sigmoid_pkg::*;
(
    input  seg_t      seg,
    output seg_coef_t coef
);

    // Select the coefficient pair for the current segment
    always_comb begin
        coef = '{g: GRAD_TBL[5], o: OFFS_TBL[5]};
        case (seg)
            3'd0:    coef = '{g: GRAD_TBL[0], o: OFFS_TBL[0]};
            3'd1:    coef = '{g: GRAD_TBL[1], o: OFFS_TBL[1]};
            3'd2:    coef = '{g: GRAD_TBL[2], o: OFFS_TBL[2]};
            3'd3:    coef = '{g: GRAD_TBL[3], o: OFFS_TBL[3]};
            3'd4:    coef = '{g: GRAD_TBL[4], o: OFFS_TBL[4]};
            3'd5:    coef = '{g: GRAD_TBL[5], o: OFFS_TBL[5]};
            default: coef = '{g: GRAD_TBL[5], o: OFFS_TBL[5]};
        endcase
    end

endmodule

// File: rtl/sigmoid_pwl.sv
// Two-stage piecewise-linear sigmoid: signed Q8.8 in, unsigned Q8.8 out.
// Stage 1 folds the operand to |x| and picks the segment; stage 2 does
// the multiply-add, clamps at 1.0 and mirrors the result for negative x.
module sigmoid_pwl
    import sigmoid_pkg::*;
#(
    parameter int BITS = SIG_BITS,
    parameter int FRAC = SIG_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    sigmoid_pwl_if.slave bus
);

    generate
        if (BITS != 16 || FRAC != 8) begin : g_bad_cfg
            $error("sigmoid_pwl supports only BITS=16, FRAC=8");
        end
    endgenerate

    logic [15:0] ax_s;
    seg_t        seg_s;
    logic [15:0] ax_r;
    seg_t        seg_r;
    logic        neg_r;
    logic        vld1_r;
    seg_coef_t   coef_s;
    logic [31:0] prod_s;
    logic [31:0] sum_s;
    logic [15:0] yp_s;
    logic [15:0] res_s;
    logic [15:0] alfa_r;
    logic        out_valid_r;

    // Absolute value; the most negative code saturates to 0x7FFF
    always_comb begin
        ax_s = bus.x;
        if (bus.x[15]) begin
            if (bus.x == 16'h8000) begin
                ax_s = 16'h7FFF;
            end else begin
                ax_s = 16'h0000 - bus.x;
            end
        end else begin
            ax_s = bus.x;
        end
    end

    // Integer part picks the segment, everything from 5 up shares the tail
    always_comb begin
        seg_s = SEG_MAX;
        if (ax_s[15:8] >= 8'd5) begin
            seg_s = SEG_MAX;
        end else begin
            seg_s = ax_s[10:8];
        end
    end

    // Stage 1 registers: folded operand, segment, sign, valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_r   <= 16'h0000;
            seg_r  <= 3'd0;
            neg_r  <= 1'b0;
            vld1_r <= 1'b0;
        end else begin
            ax_r   <= ax_s;
            seg_r  <= seg_s;
            neg_r  <= bus.x[15];
            vld1_r <= bus.in_valid;
        end
    end

    sigmoid_seg_lut u_lut (
        .seg  (seg_r),
        .coef (coef_s)
    );

    // Multiply-add with truncation, clamp at 1.0, mirror for negative x
    always_comb begin
        prod_s = {16'h0000, coef_s.g} * {16'h0000, ax_r};
        sum_s  = (prod_s >> 8) + {16'h0000, coef_s.o};
        yp_s   = ONE_Q88;
        if (sum_s > {16'h0000, ONE_Q88}) begin
            yp_s = ONE_Q88;
        end else begin
            yp_s = sum_s[15:0];
        end
        if (neg_r) begin
            res_s = ONE_Q88 - yp_s;
        end else begin
            res_s = yp_s;
        end
    end

    // Stage 2 registers: result and its valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alfa_r      <= 16'h0000;
            out_valid_r <= 1'b0;
        end else begin
            alfa_r      <= res_s;
            out_valid_r <= vld1_r;
        end
    end

    assign bus.alfa      = alfa_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_sigmoid_pwl.sv
// Directed bench for sigmoid_pwl with hand-computed expected values.
module tb_sigmoid_pwl;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   bad_cnt;

    sigmoid_pwl_if #(.BITS(16)) bus ();

    sigmoid_pwl #(.BITS(16), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    // One isolated sample: result is visible after the second edge
    task automatic run_vec(input string tag, input logic [15:0] xv, input logic [15:0] exp);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x        = 16'h0000;
        @(posedge clk); #1;
        check_val({tag, "_vld"}, {15'h0000, bus.out_valid}, 16'h0001);
        check_val(tag, bus.alfa, exp);
    endtask

    localparam int NSTR = 13;
    logic [15:0] str_x   [NSTR];
    logic [15:0] str_exp [NSTR];
    logic        str_vld [NSTR];

    initial begin
        total_cnt    = 0;
        bad_cnt      = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = 16'h0000;

        // reset state
        #12;
        check_val("rst_vld", {15'h0000, bus.out_valid}, 16'h0000);
        check_val("rst_alfa", bus.alfa, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // integer points
        run_vec("int0", 16'h0000, 16'h0080);
        run_vec("int1", 16'h0100, 16'h00B6);
        run_vec("int2", 16'h0200, 16'h00E1);
        run_vec("int3", 16'h0300, 16'h00F5);
        run_vec("int4", 16'h0400, 16'h00FC);
        run_vec("int5", 16'h0500, 16'h00FE);
        // negative symmetry
        run_vec("neg1", 16'hFF00, 16'h004A);
        run_vec("neg2", 16'hFE00, 16'h001F);
        run_vec("neg3", 16'hFD00, 16'h000B);
        run_vec("neg4", 16'hFC00, 16'h0004);
        run_vec("neg5", 16'hFB00, 16'h0002);
        // saturation
        run_vec("sat_max", 16'h7FFF, 16'h0100);
        run_vec("sat_min", 16'h8000, 16'h0000);
        run_vec("sat_ten", 16'h0A00, 16'h0100);
        // fraction and segment edge
        run_vec("half",   16'h0080, 16'h009D);
        run_vec("edge_lo", 16'h00FF, 16'h00BA);
        run_vec("edge_hi", 16'h0100, 16'h00B6);
        run_vec("neg_half", 16'hFF80, 16'h0063);

        // streaming: 10 back-to-back, a bubble, then two more
        str_x = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                  16'hFF00, 16'hFE00, 16'h0080, 16'h00FF, 16'h0300, 16'hFC00, 16'h7FFF};
        str_exp = '{16'h0080, 16'h00B6, 16'h00E1, 16'h00F5, 16'h00FC, 16'h00FE,
                    16'h004A, 16'h001F, 16'h009D, 16'h00BA, 16'h0000, 16'h0004, 16'h0100};
        str_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1};
        for (int c = 0; c < NSTR + 2; c++) begin
            if (c < NSTR) begin
                bus.in_valid = str_vld[c];
                bus.x        = str_x[c];
            end else begin
                bus.in_valid = 1'b0;
                bus.x        = 16'h0000;
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= NSTR) begin
                check_val($sformatf("str_vld%0d", c - 1), {15'h0000, bus.out_valid},
                          {15'h0000, str_vld[c - 1]});
                if (str_vld[c - 1]) begin
                    check_val($sformatf("str_alfa%0d", c - 1), bus.alfa, str_exp[c - 1]);
                end
            end
        end

        // reset with two samples in flight
        bus.in_valid = 1'b1;
        bus.x        = 16'h0100;
        @(posedge clk); #1;
        bus.x        = 16'h0200;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x        = 16'h0000;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", {15'h0000, bus.out_valid}, 16'h0000);
        check_val("mid_rst_alfa", bus.alfa, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("post_rst_vld%0d", k), {15'h0000, bus.out_valid}, 16'h0000);
        end
        run_vec("recover", 16'h0300, 16'h00F5);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
